// File: rtl/updown_mod_counter_pkg.sv
// rtl/updown_mod_counter_pkg.sv - shared mode constants for the up/down modulo counter
// Purpose : named values for the SATURATE and EDGE_MODE parameters.
// Ports   : none (package).
package updown_mod_counter_pkg;

  localparam int MODE_WRAP  = 0;  // wrap around at range ends
  localparam int MODE_SAT   = 1;  // hold at range ends
  localparam int EDGE_LEVEL = 0;  // count every enabled cycle the strobe is high
  localparam int EDGE_RISE  = 1;  // count only on a strobe 0->1 transition

endpackage

// File: rtl/updown_mod_counter_strobe_edge_detect.sv
// rtl/updown_mod_counter_strobe_edge_detect.sv - rising-edge detector for a count strobe
// Purpose : flags the cycle in which d is high after being low the cycle before.
// Ports   : clk, reset (sync, active-high), d (strobe in), q_rise (d & ~previous d).
module strobe_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q_rise
);

  logic d_q;

  // History is sampled every cycle, independent of enable or load, so a
  // strobe held high through a load still counts as already seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign q_rise = d & ~d_q;

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - parametrised up/down modulo counter with load, tc and sticky flags
// Purpose : counts 0..MOD-1 up or down, wrapping or saturating at the ends.
// Ports   : clk, reset (sync, active-high), en, count_up, count_down, load,
//           load_val[WIDTH-1:0], clr_flags -> count[WIDTH-1:0] (registered),
//           at_max, at_zero (combinational), tc (registered pulse), ovf, udf (sticky).
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MOD       = 8,
  parameter int SATURATE  = MODE_WRAP,
  parameter int EDGE_MODE = EDGE_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             count_up,
  input  logic             count_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  generate
    if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
      $error("updown_mod_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
    end
  endgenerate

  // The top of the count range always fits in WIDTH bits, so no WIDTH+1
  // comparisons are needed, and a full-range modulus wraps with plain rollover.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

  logic up_ev;
  logic dn_ev;
  logic inc;
  logic dec;
  logic [WIDTH-1:0] load_clamped;

  generate
    if (EDGE_MODE == EDGE_RISE) begin : g_edge
      strobe_edge_detect u_up_edge (
        .clk    (clk),
        .reset  (reset),
        .d      (count_up),
        .q_rise (up_ev)
      );
      strobe_edge_detect u_dn_edge (
        .clk    (clk),
        .reset  (reset),
        .d      (count_down),
        .q_rise (dn_ev)
      );
    end else begin : g_level
      assign up_ev = count_up;
      assign dn_ev = count_down;
    end
  endgenerate

  // Opposing events in the same cycle cancel out.
  assign inc = en & up_ev & ~dn_ev;
  assign dec = en & dn_ev & ~up_ev;

  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      tc <= 1'b0;
      // Clear first so a boundary event later in this block wins.
      if (clr_flags) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end
      if (load) begin
        count <= load_clamped;
      end else if (inc) begin
        if (at_max) begin
          tc  <= 1'b1;
          ovf <= 1'b1;
          if (SATURATE == MODE_WRAP) begin
            count <= '0;
          end
        end else begin
          count <= count + WIDTH'(1);
        end
      end else if (dec) begin
        if (at_zero) begin
          tc  <= 1'b1;
          udf <= 1'b1;
          if (SATURATE == MODE_WRAP) begin
            count <= MAX_VAL;
          end
        end else begin
          count <= count - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - self-checking bench for updown_mod_counter
module tb_updown_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       count_up = 1'b0;
  logic       count_down = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic       clr_flags = 1'b0;

  logic [2:0] cnt   [4];
  logic       amax  [4];
  logic       azero [4];
  logic       tcs   [4];
  logic       ovfs  [4];
  logic       udfs  [4];

  int vectors = 0;
  int miscompares = 0;

  // Instance configurations: 0 wrap MOD6, 1 saturate MOD6, 2 edge wrap MOD8, 3 saturate MOD8
  int p_mod  [4] = '{6, 6, 8, 8};
  int p_sat  [4] = '{0, 1, 0, 1};
  int p_edge [4] = '{0, 0, 1, 0};

  updown_mod_counter #(.WIDTH(3), .MOD(6), .SATURATE(0), .EDGE_MODE(0)) u0 (
    .clk(clk), .reset(reset), .en(en), .count_up(count_up), .count_down(count_down),
    .load(load), .load_val(load_val), .clr_flags(clr_flags), .count(cnt[0]),
    .at_max(amax[0]), .at_zero(azero[0]), .tc(tcs[0]), .ovf(ovfs[0]), .udf(udfs[0]));
  updown_mod_counter #(.WIDTH(3), .MOD(6), .SATURATE(1), .EDGE_MODE(0)) u1 (
    .clk(clk), .reset(reset), .en(en), .count_up(count_up), .count_down(count_down),
    .load(load), .load_val(load_val), .clr_flags(clr_flags), .count(cnt[1]),
    .at_max(amax[1]), .at_zero(azero[1]), .tc(tcs[1]), .ovf(ovfs[1]), .udf(udfs[1]));
  updown_mod_counter #(.WIDTH(3), .MOD(8), .SATURATE(0), .EDGE_MODE(1)) u2 (
    .clk(clk), .reset(reset), .en(en), .count_up(count_up), .count_down(count_down),
    .load(load), .load_val(load_val), .clr_flags(clr_flags), .count(cnt[2]),
    .at_max(amax[2]), .at_zero(azero[2]), .tc(tcs[2]), .ovf(ovfs[2]), .udf(udfs[2]));
  updown_mod_counter #(.WIDTH(3), .MOD(8), .SATURATE(1), .EDGE_MODE(0)) u3 (
    .clk(clk), .reset(reset), .en(en), .count_up(count_up), .count_down(count_down),
    .load(load), .load_val(load_val), .clr_flags(clr_flags), .count(cnt[3]),
    .at_max(amax[3]), .at_zero(azero[3]), .tc(tcs[3]), .ovf(ovfs[3]), .udf(udfs[3]));

  // Reference model: plain integer arithmetic on the counting rules.
  int m_cnt [4];
  bit m_tc  [4];
  bit m_ovf [4];
  bit m_udf [4];
  bit m_pu  [4];
  bit m_pd  [4];

  task automatic step(input logic r, input logic e, input logic u, input logic d,
                      input logic l, input logic [2:0] lv, input logic cf);
    reset = r; en = e; count_up = u; count_down = d; load = l; load_val = lv; clr_flags = cf;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      bit ue, de, so, su;
      if (r) begin
        m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_udf[i] = 0; m_pu[i] = 0; m_pd[i] = 0;
      end else begin
        ue = p_edge[i] ? (u && !m_pu[i]) : u;
        de = p_edge[i] ? (d && !m_pd[i]) : d;
        so = 0; su = 0; m_tc[i] = 0;
        if (l) begin
          m_cnt[i] = (int'(lv) > p_mod[i] - 1) ? p_mod[i] - 1 : int'(lv);
        end else if (e && ue && !de) begin
          if (m_cnt[i] == p_mod[i] - 1) begin
            so = 1; m_tc[i] = 1;
            m_cnt[i] = p_sat[i] ? m_cnt[i] : 0;
          end else m_cnt[i] = m_cnt[i] + 1;
        end else if (e && de && !ue) begin
          if (m_cnt[i] == 0) begin
            su = 1; m_tc[i] = 1;
            m_cnt[i] = p_sat[i] ? 0 : p_mod[i] - 1;
          end else m_cnt[i] = m_cnt[i] - 1;
        end
        m_ovf[i] = so | (m_ovf[i] & !cf);
        m_udf[i] = su | (m_udf[i] & !cf);
        m_pu[i] = u; m_pd[i] = d;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 1, 0, 0, 3'd0, 0);
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if ({cnt[i], tcs[i], ovfs[i], udfs[i]} !== 6'b0) begin
          miscompares++;
          $display("FAIL reset inst%0d cyc%0d: count=%0d tc=%b ovf=%b udf=%b, want all 0",
                   i, k, cnt[i], tcs[i], ovfs[i], udfs[i]);
        end
      end
    end
  endtask

  task automatic test_wrap_up();
    int exp_c [7] = '{1, 2, 3, 4, 5, 0, 1};
    for (int k = 0; k < 7; k++) begin
      step(0, 1, 1, 0, 0, 3'd0, 0);
      vectors++;
      if (cnt[0] !== 3'(exp_c[k]) || tcs[0] !== (k == 5)) begin
        miscompares++;
        $display("FAIL wrap_up cyc%0d: count=%0d tc=%b, want count=%0d tc=%b",
                 k, cnt[0], tcs[0], exp_c[k], (k == 5));
      end
    end
    vectors++;
    if (ovfs[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_up_ovf: ovf=%b, want 1", ovfs[0]);
    end
  endtask

  task automatic test_saturate_down();
    int exp_c [4] = '{1, 0, 0, 0};
    bit exp_t [4] = '{0, 0, 1, 1};
    step(0, 1, 0, 0, 1, 3'd2, 1);
    vectors++;
    if (cnt[1] !== 3'd2 || udfs[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_load: count=%0d udf=%b, want 2 0", cnt[1], udfs[1]);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 1, 0, 3'd0, 0);
      vectors++;
      if (cnt[1] !== 3'(exp_c[k]) || tcs[1] !== exp_t[k]) begin
        miscompares++;
        $display("FAIL sat_down cyc%0d: count=%0d tc=%b, want count=%0d tc=%b",
                 k, cnt[1], tcs[1], exp_c[k], exp_t[k]);
      end
    end
    vectors++;
    if (udfs[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_udf: udf=%b, want 1", udfs[1]);
    end
    step(0, 0, 0, 0, 0, 3'd0, 1);
    vectors++;
    if (udfs[1] !== 1'b0 || tcs[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_clr: udf=%b tc=%b, want 0 0", udfs[1], tcs[1]);
    end
  endtask

  task automatic test_load_priority();
    step(0, 1, 1, 0, 1, 3'd7, 0);
    vectors++;
    if (cnt[0] !== 3'd5 || tcs[0] !== 1'b0 || cnt[3] !== 3'd7) begin
      miscompares++;
      $display("FAIL load_clamp: count0=%0d tc0=%b count3=%0d, want 5 0 7", cnt[0], tcs[0], cnt[3]);
    end
    step(0, 1, 1, 1, 0, 3'd0, 0);
    vectors++;
    if (cnt[0] !== 3'd5 || tcs[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL both_strobes: count=%0d tc=%b, want 5 0", cnt[0], tcs[0]);
    end
  endtask

  task automatic test_edge_mode();
    bit tog [5] = '{1, 0, 1, 0, 1};
    step(1, 0, 0, 0, 0, 3'd0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 1, 0, 0, 3'd0, 0);
    vectors++;
    if (cnt[2] !== 3'd1) begin
      miscompares++;
      $display("FAIL edge_held: count=%0d, want 1", cnt[2]);
    end
    for (int k = 0; k < 5; k++) step(0, 1, tog[k], 0, 0, 3'd0, 0);
    vectors++;
    if (cnt[2] !== 3'd3) begin
      miscompares++;
      $display("FAIL edge_toggle: count=%0d, want 3", cnt[2]);
    end
  endtask

  task automatic test_gating_reset();
    step(1, 0, 0, 0, 0, 3'd0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 0, 3'd0, 0);
    vectors++;
    if (cnt[0] !== 3'd4) begin
      miscompares++;
      $display("FAIL gate_setup: count=%0d, want 4", cnt[0]);
    end
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1'($urandom), 1'($urandom), 0, 3'd0, 0);
      vectors++;
      if (cnt[0] !== 3'd4 || tcs[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL gate_frozen cyc%0d: count=%0d tc=%b, want 4 0", k, cnt[0], tcs[0]);
      end
    end
    step(1, 1, 1, 0, 1, 3'd3, 0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (cnt[i] !== 3'd0) begin
        miscompares++;
        $display("FAIL reset_mid inst%0d: count=%0d, want 0", i, cnt[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom), ($urandom_range(0, 7) == 0), 3'($urandom), ($urandom_range(0, 7) == 0));
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (cnt[i] !== 3'(m_cnt[i]) || tcs[i] !== m_tc[i] || ovfs[i] !== m_ovf[i] ||
            udfs[i] !== m_udf[i] || amax[i] !== (m_cnt[i] == p_mod[i] - 1) ||
            azero[i] !== (m_cnt[i] == 0)) begin
          miscompares++;
          $display("FAIL random inst%0d cyc%0d: got c=%0d tc=%b o=%b u=%b mx=%b z=%b, want c=%0d tc=%b o=%b u=%b",
                   i, k, cnt[i], tcs[i], ovfs[i], udfs[i], amax[i], azero[i],
                   m_cnt[i], m_tc[i], m_ovf[i], m_udf[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_saturate_down();
    test_load_priority();
    test_edge_mode();
    test_gating_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
